// File: rtl/compare_pkg.sv
// ---------------------------------------------------------------------------
// compare_pkg : result codes, FSM state type and cascade decode helper
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package compare_pkg;

  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Malformed cascade codes fall back to "equal" so the result stays one-hot.
  function automatic logic [2:0] decode_cascade(input logic [2:0] code);
    logic [2:0] res;
    case (code)
      RES_GT:  res = RES_GT;
      RES_LT:  res = RES_LT;
      default: res = RES_EQ;
    endcase
    return res;
  endfunction

endpackage : compare_pkg

`default_nettype wire

// File: rtl/slice_compare.sv
// ---------------------------------------------------------------------------
// slice_compare : combinational unsigned magnitude comparator for one slice
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module slice_compare #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             gt_o,
  output logic             lt_o,
  output logic             eq_o
);

  assign gt_o = (a_i >  b_i);
  assign lt_o = (a_i <  b_i);
  assign eq_o = (a_i == b_i);

endmodule : slice_compare

`default_nettype wire

// File: rtl/serial_compare.sv
// ---------------------------------------------------------------------------
// serial_compare : multi-cycle magnitude comparator, MSB slice first, with
//                  cascade input used when all slices are equal
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module serial_compare
  import compare_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SLICE  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic [2:0]       iData,
  output logic             oValid,
  output logic [2:0]       oData
);

  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(N - 1);

  if ((WIDTH % SLICE) != 0 || SLICE < 1) begin : g_bad_slice
    $error("serial_compare: WIDTH must be an integer multiple of SLICE");
  end

  state_e            state_q;
  logic              ready_q;
  logic              valid_q;
  logic [2:0]        data_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [2:0]        casc_q;
  logic [IDXW-1:0]   idx_q;

  logic [WIDTH-1:0]  w_a_cmp;
  logic [WIDTH-1:0]  w_b_cmp;
  logic [SLICE-1:0]  w_a_sel;
  logic [SLICE-1:0]  w_b_sel;
  logic              w_gt;
  logic              w_lt;
  logic              w_eq;

  // The MSB lives only in slice N-1, so flipping it here biases two's-complement
  // operands into unsigned order without touching the lower slices.
  always_comb begin
    w_a_cmp = a_q;
    w_b_cmp = b_q;
    if (SIGNED) begin
      w_a_cmp[WIDTH-1] = ~a_q[WIDTH-1];
      w_b_cmp[WIDTH-1] = ~b_q[WIDTH-1];
    end
  end

  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int s = 0; s < N; s++) begin
      if (idx_q == IDXW'(s)) begin
        w_a_sel = w_a_cmp[s*SLICE +: SLICE];
        w_b_sel = w_b_cmp[s*SLICE +: SLICE];
      end
    end
  end

  slice_compare #(
    .WIDTH (SLICE)
  ) u_slice_compare (
    .a_i  (w_a_sel),
    .b_i  (w_b_sel),
    .gt_o (w_gt),
    .lt_o (w_lt),
    .eq_o (w_eq)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= RES_NONE;
      a_q     <= '0;
      b_q     <= '0;
      casc_q  <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iValid) begin
            a_q     <= iData_a;
            b_q     <= iData_b;
            casc_q  <= iData;
            idx_q   <= IDX_MAX;
            ready_q <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_gt) begin
            data_q  <= RES_GT;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else if (w_lt) begin
            data_q  <= RES_LT;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else if (w_eq && idx_q != '0) begin
            idx_q   <= idx_q - 1'b1;
          end else begin
            data_q  <= decode_cascade(casc_q);
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign oReady = ready_q;
  assign oValid = valid_q;
  assign oData  = data_q;

endmodule : serial_compare

`default_nettype wire

// File: tb/tb_serial_compare.sv
// ---------------------------------------------------------------------------
// tb_serial_compare : directed scoreboard bench, unsigned and signed instances
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_compare;

  localparam int W  = 16;
  localparam int SL = 4;
  localparam int NS = W / SL;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         vld = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic [2:0]   c   = '0;

  logic         rdy_u, vo_u, rdy_s, vo_s;
  logic [2:0]   d_u, d_s;

  int checks = 0;
  int errors = 0;

  logic [2:0] q_u[$];
  logic [2:0] q_s[$];

  always #5 clk = ~clk;

  serial_compare #(.WIDTH(W), .SLICE(SL), .SIGNED(1'b0)) u_dut_u (
    .iClk(clk), .iRst(rst), .iValid(vld), .oReady(rdy_u),
    .iData_a(a), .iData_b(b), .iData(c), .oValid(vo_u), .oData(d_u)
  );

  serial_compare #(.WIDTH(W), .SLICE(SL), .SIGNED(1'b1)) u_dut_s (
    .iClk(clk), .iRst(rst), .iValid(vld), .oReady(rdy_s),
    .iData_a(a), .iData_b(b), .iData(c), .oValid(vo_s), .oData(d_s)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] cas_dec(input logic [2:0] code);
    if (code == 3'b100) return 3'b100;
    if (code == 3'b010) return 3'b010;
    return 3'b001;
  endfunction

  function automatic void model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                input logic [2:0] ci, output logic [2:0] eu,
                                output logic [2:0] es, output int lat);
    int k = 0;
    for (int s = NS - 1; s >= 0; s--) begin
      k++;
      if (ai[s*SL +: SL] != bi[s*SL +: SL]) break;
    end
    lat = k + 1;
    eu  = (ai > bi) ? 3'b100 : (ai < bi) ? 3'b010 : cas_dec(ci);
    es  = ($signed(ai) > $signed(bi)) ? 3'b100 :
          ($signed(ai) < $signed(bi)) ? 3'b010 : cas_dec(ci);
  endfunction

  // Cycle 0 is the accept cycle; the result pulse is expected in cycle lat.
  task automatic do_req(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic [2:0] ci, input bit hold);
    logic [2:0] eu, es, got;
    int lat;
    model(ai, bi, ci, eu, es, lat);
    @(posedge clk); #1;
    vld = 1'b1; a = ai; b = bi; c = ci;
    @(negedge clk);
    check("accept_rdy_u", {3'b0, rdy_u}, 4'd1);
    check("accept_rdy_s", {3'b0, rdy_s}, 4'd1);
    q_u.push_back(eu);
    q_s.push_back(es);
    for (int n = 1; n <= lat; n++) begin
      @(posedge clk); #1;
      if (hold) begin
        a = W'($urandom);
        b = W'($urandom);
        c = 3'($urandom_range(7));
      end else begin
        vld = 1'b0;
      end
      @(negedge clk);
      check("busy_rdy_u", {3'b0, rdy_u}, 4'd0);
      check("busy_rdy_s", {3'b0, rdy_s}, 4'd0);
      check("valid_u", {3'b0, vo_u}, {3'b0, n == lat});
      check("valid_s", {3'b0, vo_s}, {3'b0, n == lat});
      if (vo_u && q_u.size() > 0) begin
        got = q_u.pop_front();
        check("data_u", {1'b0, d_u}, {1'b0, got});
      end
      if (vo_s && q_s.size() > 0) begin
        got = q_s.pop_front();
        check("data_s", {1'b0, d_s}, {1'b0, got});
      end
    end
    check("pending_u", 4'(q_u.size()), 4'd0);
    check("pending_s", 4'(q_s.size()), 4'd0);
    q_u.delete();
    q_s.delete();
    if (!hold) begin
      @(negedge clk);
      check("idle_rdy_u", {3'b0, rdy_u}, 4'd1);
      check("idle_valid_u", {3'b0, vo_u}, 4'd0);
      check("hold_data_u", {1'b0, d_u}, {1'b0, eu});
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy_u", {3'b0, rdy_u}, 4'd1);
    check("rst_valid_u", {3'b0, vo_u}, 4'd0);
    check("rst_data_u", {1'b0, d_u}, 4'd0);
    check("rst_data_s", {1'b0, d_s}, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_req(16'h1234, 16'h1234, 3'b100, 1'b0);
    do_req(16'hA000, 16'h9FFF, 3'b000, 1'b0);
    do_req(16'h0001, 16'h0002, 3'b000, 1'b0);
    do_req(16'hFFFF, 16'h0001, 3'b000, 1'b0);
    do_req(16'h5A5A, 16'h5A5A, 3'b000, 1'b0);
    do_req(16'h5A5A, 16'h5A5A, 3'b011, 1'b0);
    do_req(16'h8000, 16'h7FFF, 3'b010, 1'b0);
    do_req(16'hC3C3, 16'hC3C3, 3'b010, 1'b1);
    do_req(16'h5678, 16'h5679, 3'b100, 1'b0);

    // Abandon a request with reset in its second RUN cycle.
    @(posedge clk); #1;
    vld = 1'b1; a = 16'h4444; b = 16'h4444; c = 3'b100;
    @(negedge clk);
    check("rstrun_accept", {3'b0, rdy_u}, 4'd1);
    @(posedge clk); #1;
    vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstrun_busy", {3'b0, rdy_u}, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstrun_rdy_u", {3'b0, rdy_u}, 4'd1);
    check("rstrun_data_u", {1'b0, d_u}, 4'd0);
    check("rstrun_data_s", {1'b0, d_s}, 4'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rstrun_novalid", {3'b0, vo_u | vo_s}, 4'd0);
    end

    // Reset and request in the same cycle: nothing is accepted.
    @(posedge clk); #1;
    rst = 1'b1; vld = 1'b1; a = 16'h0010; b = 16'h0001;
    @(posedge clk); #1;
    rst = 1'b0; vld = 1'b0;
    @(negedge clk);
    check("rstvld_rdy", {3'b0, rdy_u}, 4'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rstvld_novalid", {3'b0, vo_u | vo_s}, 4'd0);
    end

    do_req(16'h0010, 16'h0001, 3'b000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_compare

`default_nettype wire
